// File: rtl/maze_map_if.sv
`timescale 1ns/1ps
// Solver/load/dump port bundle for maze_map: the master drives the load stream,
// the solver accesses and out_ready; the slave is the map itself.
interface maze_map_if #(parameter int AW = 6);
    logic            load_valid;
    logic            load_ready;
    logic [1:0]      load_cell;
    logic            map_ready;
    logic [AW-1:0]   row;
    logic [AW-1:0]   col;
    logic            maze_oe;
    logic            maze_we;
    logic            maze_in;
    logic            done;
    logic [2*AW:0]   path_count;
    logic            bad_write;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_row;
    logic [AW-1:0]   out_col;
    logic            dump_done;

    modport master (
        output load_valid, load_cell, row, col, maze_oe, maze_we, done, out_ready,
        input  load_ready, map_ready, maze_in, path_count, bad_write,
               out_valid, out_row, out_col, dump_done
    );

    modport slave (
        input  load_valid, load_cell, row, col, maze_oe, maze_we, done, out_ready,
        output load_ready, map_ready, maze_in, path_count, bad_write,
               out_valid, out_row, out_col, dump_done
    );
endinterface

// File: rtl/maze_map.sv
`timescale 1ns/1ps
// DIM x DIM 2-bit maze cell store: raster load, solver read/mark, path-cell dump.
// Latency: reads registered one cycle after maze_oe; one scan cell per cycle in dump.
// Backpressure: load_ready drops after the final beat; dump scan stalls while out_valid && !out_ready.
module maze_map #(
    parameter int DIM = 64,
    parameter int AW  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    maze_map_if.slave   bus
);
    localparam int NCELL = DIM * DIM;
    localparam int PW    = 2 * AW;
    localparam int CW    = 2 * AW + 1;
    localparam logic [PW-1:0] LAST    = '1;
    localparam logic [CW-1:0] CNT_MAX = CW'(NCELL);

    typedef enum logic [1:0] {ST_LOAD, ST_SOLVE, ST_DUMP, ST_END} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            load_ready_q, load_ready_d;
    logic            map_ready_q, map_ready_d;
    logic            maze_in_q, maze_in_d;
    logic [CW-1:0]   path_count_q, path_count_d;
    logic            bad_write_q, bad_write_d;
    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   out_row_q, out_row_d;
    logic [AW-1:0]   out_col_q, out_col_d;
    logic            dump_done_q, dump_done_d;

    logic [1:0]      cell_mem [NCELL];
    logic            mem_we;
    logic [PW-1:0]   mem_addr;
    logic [1:0]      mem_wdat;
    logic [PW-1:0]   sol_addr;
    logic [1:0]      sol_cell;
    logic [1:0]      scan_cell;
    logic            cnt_inc;
    logic            scan_step;

    assign sol_addr  = {bus.row, bus.col};
    assign sol_cell  = cell_mem[sol_addr];
    assign scan_cell = cell_mem[ptr_q];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_ready_d = load_ready_q;
        map_ready_d  = map_ready_q;
        maze_in_d    = maze_in_q;
        bad_write_d  = bad_write_q;
        out_valid_d  = out_valid_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        dump_done_d  = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = ptr_q;
        mem_wdat     = 2'd0;
        cnt_inc      = 1'b0;
        scan_step    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (bus.load_valid && load_ready_q) begin
                    mem_we   = 1'b1;
                    mem_wdat = (bus.load_cell == 2'd3) ? 2'd1 : bus.load_cell;
                    cnt_inc  = (bus.load_cell == 2'd2);
                    ptr_d    = ptr_q + 1'b1;
                    if (ptr_q == LAST) begin
                        load_ready_d = 1'b0;
                        map_ready_d  = 1'b1;
                        state_d      = ST_SOLVE;
                    end
                end
            end
            ST_SOLVE: begin
                // Reads see the array before this cycle's write lands.
                if (bus.maze_oe)
                    maze_in_d = (sol_cell == 2'd1);
                if (bus.maze_we) begin
                    mem_addr = sol_addr;
                    if (sol_cell == 2'd0) begin
                        mem_we   = 1'b1;
                        mem_wdat = 2'd2;
                        cnt_inc  = 1'b1;
                    end else if (sol_cell == 2'd1) begin
                        bad_write_d = 1'b1;
                    end
                end
                if (bus.done)
                    state_d = ST_DUMP;
            end
            ST_DUMP: begin
                if (out_valid_q) begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        scan_step   = 1'b1;
                    end
                end else if (scan_cell == 2'd2) begin
                    out_valid_d = 1'b1;
                    out_row_d   = ptr_q[PW-1:AW];
                    out_col_d   = ptr_q[AW-1:0];
                end else begin
                    scan_step = 1'b1;
                end
            end
            ST_END: begin
            end
        endcase

        if (scan_step) begin
            if (ptr_q == LAST) begin
                dump_done_d = 1'b1;
                state_d     = ST_END;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end

        path_count_d = (cnt_inc && path_count_q != CNT_MAX) ? path_count_q + 1'b1 : path_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            load_ready_q <= 1'b1;
            map_ready_q  <= 1'b0;
            maze_in_q    <= 1'b0;
            path_count_q <= '0;
            bad_write_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_ready_q <= load_ready_d;
            map_ready_q  <= map_ready_d;
            maze_in_q    <= maze_in_d;
            path_count_q <= path_count_d;
            bad_write_q  <= bad_write_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            dump_done_q  <= dump_done_d;
        end
    end

    // The cell array is deliberately not reset; every run starts with a full load.
    always_ff @(posedge clk) begin
        if (mem_we)
            cell_mem[mem_addr] <= mem_wdat;
    end

    assign bus.load_ready = load_ready_q;
    assign bus.map_ready  = map_ready_q;
    assign bus.maze_in    = maze_in_q;
    assign bus.path_count = path_count_q;
    assign bus.bad_write  = bad_write_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.dump_done  = dump_done_q;
endmodule

// File: tb/tb_maze_map.sv
`timescale 1ns/1ps
// Bench for maze_map: grid model as a 2-D array of cell values, updated by the cell rules.
module tb_maze_map;
    localparam int DIM = 64;
    localparam int AW  = 6;
    localparam int N   = DIM * DIM;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maze_map_if #(.AW(AW)) bus();

    maze_map #(.DIM(DIM), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int mg  [DIM][DIM];
    int src [DIM][DIM];
    int m_cnt;
    int m_bad;
    int m_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst_load_ready", bus.load_ready, 1);
        check("rst_map_ready",  bus.map_ready,  0);
        check("rst_maze_in",    bus.maze_in,    0);
        check("rst_path_count", bus.path_count, 0);
        check("rst_bad_write",  bus.bad_write,  0);
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_out_row",    bus.out_row,    0);
        check("rst_out_col",    bus.out_col,    0);
        check("rst_dump_done",  bus.dump_done,  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_cnt = 0;
        m_bad = 0;
        m_in  = 0;
    endtask

    // Drives src[][] in raster order with random valid gaps; stops after stop_at beats.
    task automatic load_grid(input int stop_at);
        int beat = 0;
        while (beat < stop_at) begin
            int r = beat / DIM;
            int c = beat % DIM;
            bus.load_valid = ($urandom_range(0, 7) != 0);
            bus.load_cell  = 2'(src[r][c]);
            if (bus.load_valid) begin
                mg[r][c] = (src[r][c] == 3) ? 1 : src[r][c];
                if (src[r][c] == 2) m_cnt++;
                beat++;
            end
            tick();
        end
        bus.load_valid = 1'b0;
        if (stop_at == N) begin
            check("load_ready_after_last", bus.load_ready, 0);
            check("map_ready_after_load",  bus.map_ready,  1);
            check("path_count_after_load", bus.path_count, m_cnt);
        end
    endtask

    task automatic sol_op(input bit oe, input bit we, input int r, input int c);
        int pre = mg[r][c];
        bus.row     = AW'(r);
        bus.col     = AW'(c);
        bus.maze_oe = oe;
        bus.maze_we = we;
        if (oe) m_in = (pre == 1);
        if (we) begin
            if (pre == 0) begin
                mg[r][c] = 2;
                if (m_cnt < N) m_cnt++;
            end else if (pre == 1) begin
                m_bad = 1;
            end
        end
        tick();
        bus.maze_oe = 1'b0;
        bus.maze_we = 1'b0;
        check("maze_in",    bus.maze_in,    m_in);
        check("path_count", bus.path_count, m_cnt);
        check("bad_write",  bus.bad_write,  m_bad);
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++)
            sol_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7), $urandom_range(0, DIM - 1));
    endtask

    task automatic raise_done();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < N + 10 && !bus.out_valid; k++) tick();
        check("wait_out_valid", bus.out_valid, 1);
    endtask

    task automatic dump_run(input bit rnd);
        int exp_r[$];
        int exp_c[$];
        int idx = 0;
        bit prev_pend = 0;
        bit seen_done = 0;
        int pr = 0;
        int pc = 0;
        bit rdy;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                if (mg[r][c] == 2) begin
                    exp_r.push_back(r);
                    exp_c.push_back(c);
                end
        for (int cyc = 0; cyc < 3 * N; cyc++) begin
            if (bus.dump_done) begin
                seen_done = 1;
                break;
            end
            if (prev_pend) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_row",   bus.out_row,   pr);
                check("stall_col",   bus.out_col,   pc);
            end
            rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.out_ready = rdy;
            prev_pend = 0;
            if (bus.out_valid) begin
                if (rdy) begin
                    if (idx < exp_r.size()) begin
                        check("beat_row", bus.out_row, exp_r[idx]);
                        check("beat_col", bus.out_col, exp_c[idx]);
                    end else begin
                        check("extra_beat", idx, exp_r.size());
                    end
                    idx++;
                end else begin
                    prev_pend = 1;
                    pr = bus.out_row;
                    pc = bus.out_col;
                end
            end
            tick();
        end
        bus.out_ready = 1'b0;
        check("dump_done_seen", seen_done, 1);
        check("beat_count", idx, exp_r.size());
        tick();
        check("dump_done_one_cycle", bus.dump_done, 0);
    endtask

    initial begin
        int k;
        bus.load_valid = 0; bus.load_cell = 0; bus.row = 0; bus.col = 0;
        bus.maze_oe = 0; bus.maze_we = 0; bus.done = 0; bus.out_ready = 0;
        do_reset();

        // Directed grid: walls everywhere except (1,1)..(1,5).
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                src[r][c] = (r == 1 && c >= 1 && c <= 5) ? 0 : 1;
        load_grid(N);

        sol_op(1, 0, 1, 3);
        check("read_free", bus.maze_in, 0);
        sol_op(1, 0, 0, 0);
        check("read_wall", bus.maze_in, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("maze_in_hold", bus.maze_in, 1);
        end
        sol_op(0, 1, 1, 2);
        sol_op(0, 1, 1, 2);
        sol_op(1, 0, 1, 2);
        check("double_write_count", bus.path_count, 1);
        check("path_reads_open", bus.maze_in, 0);
        sol_op(0, 1, 0, 0);
        check("bad_write_set", bus.bad_write, 1);
        sol_op(1, 0, 0, 0);
        check("wall_unchanged", bus.maze_in, 1);
        sol_op(1, 1, 1, 4);
        check("rw_same_cycle_count", bus.path_count, 2);
        sol_op(0, 1, 1, 1);
        sol_op(0, 1, 1, 3);

        // done with a write in the same cycle: the write still counts.
        bus.row = 1; bus.col = 5; bus.maze_we = 1;
        mg[1][5] = 2; m_cnt++;
        raise_done();
        bus.maze_we = 0;
        check("write_with_done", bus.path_count, m_cnt);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("held_valid", bus.out_valid, 1);
            check("held_row", bus.out_row, 1);
            check("held_col", bus.out_col, 1);
            tick();
        end
        dump_run(0);

        // END ignores solver writes and keeps outputs.
        sol_op(0, 0, 0, 0);
        bus.row = 2; bus.col = 2; bus.maze_we = 1;
        tick();
        bus.maze_we = 0;
        check("end_path_count", bus.path_count, m_cnt);
        check("end_map_ready", bus.map_ready, 1);
        check("end_out_valid", bus.out_valid, 0);
        check("end_load_ready", bus.load_ready, 0);

        // Random grid, aborted mid-load at beat 100.
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                src[r][c] = $urandom_range(0, 3);
        load_grid(100);
        do_reset();
        load_grid(N);
        random_ops(300);
        raise_done();
        wait_valid();
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        do_reset();

        // Fresh random grid, full dump with random backpressure.
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                src[r][c] = $urandom_range(0, 3);
        load_grid(N);
        random_ops(150);
        raise_done();
        dump_run(1);

        // No path cells: dump_done after exactly one full scan.
        do_reset();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                k = $urandom_range(0, 2);
                src[r][c] = (k == 2) ? 3 : k;
            end
        load_grid(N);
        raise_done();
        k = 0;
        for (int i = 0; i < N + 50; i++) begin
            tick();
            k++;
            check("no_beat_when_empty", bus.out_valid, 0);
            if (bus.dump_done) break;
        end
        check("empty_dump_latency", k, N);
        check("empty_dump_done", bus.dump_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
